poly_mem_ctrl: RTL

- Polynomial memory that serves the vector engines (add/sub, NTT) as a memory responder.
- Engine side: a combinational read port and a synchronous write port, each carrying 96-bit words of 8 packed 12-bit coefficients.
- Host side: a valid/ready coefficient stream loader that packs 256 coefficients into 32 words, and an unloader that unpacks them back to a coefficient stream.

---
 rtl/poly_mem_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/poly_mem_ctrl.sv
// Polynomial memory for the vector engines. The engine side gets a
// combinational read port and a synchronous write port. The host side gets a
// coefficient stream loader, which packs 8 coefficients per word, and an
// unloader, which unpacks each word back into single coefficients.
module poly_mem_ctrl #(
  parameter int DEPTH          = 256,
  parameter int COEF_W         = 12,
  parameter int LANES          = 8,
  parameter int WORDS_PER_POLY = 32,
  parameter int Q              = 3329,
  localparam int AW     = $clog2(DEPTH),
  localparam int WORD_W = COEF_W * LANES,
  localparam int LW     = $clog2(LANES),
  localparam int WW     = $clog2(WORDS_PER_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eng_busy,
  input  logic [AW-1:0]     eng_rd_addr,
  output logic [WORD_W-1:0] eng_rd_data,
  input  logic              eng_w_en,
  input  logic [AW-1:0]     eng_wr_addr,
  input  logic [WORD_W-1:0] eng_wr_data,
  input  logic              ld_start,
  input  logic [AW-1:0]     ld_base,
  input  logic              ld_valid,
  input  logic [COEF_W-1:0] ld_coef,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              ul_start,
  input  logic [AW-1:0]     ul_base,
  output logic              ul_valid,
  output logic [COEF_W-1:0] ul_coef,
  input  logic              ul_ready,
  output logic              ul_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  localparam logic [COEF_W-1:0] QC        = COEF_W'(Q);
  localparam logic [LW-1:0]     LAST_LANE = LW'(LANES - 1);
  localparam logic [WW-1:0]     LAST_WORD = WW'(WORDS_PER_POLY - 1);

  logic [WORD_W-1:0] mem [DEPTH];

  logic [1:0]                   state;
  logic [AW-1:0]                base;
  logic [WW-1:0]                word;
  logic [LW-1:0]                lane;
  logic [LANES-1:0][COEF_W-1:0] pack;
  logic [LANES-1:0][COEF_W-1:0] out_buf;
  logic [LANES-1:0][COEF_W-1:0] ld_word;

  logic [COEF_W-1:0] ld_red;
  logic [AW-1:0]     poly_addr;
  logic              ld_hs;
  logic              ld_we;
  logic              last_lane;

  // Inputs never reach 2Q, so a single conditional subtract fully reduces them.
  assign ld_red    = (ld_coef >= QC) ? ld_coef - QC : ld_coef;
  assign poly_addr = base + AW'(word);   // wraps on the address width
  assign last_lane = (lane == LAST_LANE);
  assign ld_ready  = (state == S_LOAD) && !eng_busy;
  assign ld_hs     = ld_ready && ld_valid;
  assign ld_we     = ld_hs && last_lane;

  assign eng_rd_data = mem[eng_rd_addr];
  assign ul_valid    = (state == S_SEND);
  assign ul_coef     = ul_valid ? out_buf[lane] : '0;

  // The word being written includes the coefficient accepted this cycle.
  always_comb begin
    ld_word       = pack;
    ld_word[lane] = ld_red;
  end

  // Storage. The engine write comes last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (ld_we)    mem[poly_addr]   <= ld_word;
    if (eng_w_en) mem[eng_wr_addr] <= eng_wr_data;
  end

  // Load/unload sequencing with the done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      base    <= '0;
      word    <= '0;
      lane    <= '0;
      pack    <= '0;
      out_buf <= '0;
      ld_done <= 1'b0;
      ul_done <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      ul_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_start) begin
            state <= S_LOAD;
            base  <= ld_base;
            word  <= '0;
            lane  <= '0;
          end else if (ul_start) begin
            state <= S_FETCH;
            base  <= ul_base;
            word  <= '0;
          end
        end
        S_LOAD: begin
          if (ld_hs) begin
            pack[lane] <= ld_red;
            if (last_lane) begin
              lane <= '0;
              word <= word + 1'b1;
              if (word == LAST_WORD) begin
                state   <= S_IDLE;
                ld_done <= 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (!eng_busy) begin
            out_buf <= mem[poly_addr];
            lane    <= '0;
            state   <= S_SEND;
          end
        end
        default: begin // S_SEND: valid is held until the host takes it
          if (ul_ready) begin
            if (!last_lane) begin
              lane <= lane + 1'b1;
            end else if (word == LAST_WORD) begin
              state   <= S_IDLE;
              ul_done <= 1'b1;
            end else begin
              word  <= word + 1'b1;
              state <= S_FETCH;
            end
          end
        end
      endcase
    end
  end

endmodule
